// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for a small in-order processor. It owns the program
// counter (PC), drives the instruction memory address, and captures the
// returned word into the IF/ID register. A three-state controller decides when
// fetching happens:
//   IDLE   : after reset, waiting for start_req
//   RUN    : fetching one instruction per cycle
//   HALTED : the decoder saw a halt, waiting for start_req to restart
//
// Parameters
//   PC_W   program counter / instruction address width
//   CNT_W  width of the RUN-cycle counter
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   start_req      begin execution from address 0 (ignored while in RUN)
//   halt           decoder reports that the held instruction is halt
//   stall          downstream cannot accept a new instruction this cycle
//   branch_taken   redirect fetch to branch_target
//   branch_target  absolute redirect address
//   imem_addr      instruction memory address (current PC)
//   imem_data      instruction word, combinationally valid for imem_addr
//   instr_out      IF/ID instruction register, drives the decoder
//   instr_valid    instr_out holds a live instruction
//   pc_out         address from which instr_out was fetched
//   done           processor halted
//   cycle_count    number of clock edges spent in RUN (saturating)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_req,
  input  logic             halt,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       imem_data,
  output logic [8:0]       instr_out,
  output logic             instr_valid,
  output logic [PC_W-1:0]  pc_out,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]       state;
  logic [PC_W-1:0]  pc;
  logic             halt_qual;
  logic [CNT_W-1:0] count_inc;
  logic [PC_W-1:0]  pc_inc;

  assign imem_addr = pc;

  // A halt request only means something when the decoder is looking at a
  // live instruction; during a flush bubble the halt line may carry garbage.
  assign halt_qual = (state == RUN) && instr_valid && halt;

  // The counter sticks at all-ones instead of wrapping so a long run never
  // reports a misleadingly small number.
  assign count_inc = (cycle_count == {CNT_W{1'b1}}) ? cycle_count
                                                    : cycle_count + CNT_W'(1);

  // Natural wrap from the top of the address space back to 0 is intended.
  assign pc_inc = pc + PC_W'(1);

  // Controller and datapath registers. Event priority in RUN is
  // halt > branch > stall > normal fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        RUN: begin
          cycle_count <= count_inc;
          if (halt_qual) begin
            state       <= HALTED;
            instr_valid <= 1'b0;
            done        <= 1'b1;
          end else if (branch_taken) begin
            // Redirect wins over stall: the instruction in IF/ID belongs to
            // the wrong path, so it is squashed rather than held.
            pc          <= branch_target;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instr_out   <= imem_data;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc_inc;
          end
        end

        IDLE, HALTED: begin
          // The start edge only sets things up; the word at address 0 is
          // captured on the following edge, so instr_valid stays low here.
          if (start_req) begin
            state       <= RUN;
            pc          <= '0;
            cycle_count <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program counter and instruction-address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning cycle-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start_req  input  1  begin program execution from address 0.
REQ-006 SHALL have port halt  input  1  decoder reports that the held instruction is halt.
REQ-007 SHALL have port stall  input  1  downstream cannot accept a new instruction this cycle.
REQ-008 SHALL have port branch_taken  input  1  redirect fetch to branch_target.
REQ-009 SHALL have port branch_target  input  PC_W  absolute redirect address.
REQ-010 SHALL have port imem_addr  output  PC_W  instruction memory address, equal to the current PC.
REQ-011 SHALL have port imem_data  input  9  instruction word, combinationally valid for imem_addr in the same cycle.
REQ-012 SHALL have port instr_out  output  9  IF/ID register instruction, driving the decoder.
REQ-013 SHALL have port instr_valid  output  1  instr_out holds a live instruction.
REQ-014 SHALL have port pc_out  output  PC_W  address from which instr_out was fetched.
REQ-015 SHALL have port done  output  1  processor halted.
REQ-016 SHALL have port cycle_count  output  CNT_W  clock cycles spent in RUN.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HALTED; IDLE->RUN on start_req; RUN->HALTED on qualified halt; HALTED->RUN on start_req; no other transitions.
REQ-018 SHALL, on IDLE/HALTED->RUN, set PC=0, clear cycle_count and keep instr_valid=0 for that edge; first fetch (address 0) captured on the next edge.
REQ-019 SHALL, in RUN with no stall/branch/halt, load instr_out<=imem_data, pc_out<=PC, instr_valid<=1, PC<=PC+1 each edge (one instruction per cycle, one-cycle latency address->instr_out).
REQ-020 SHALL wrap PC from 2^PC_W-1 to 0 without error indication.
REQ-021 SHALL, in RUN with stall=1, hold PC, instr_out, pc_out and instr_valid.
REQ-022 SHALL, on branch_taken=1 in RUN, load PC<=branch_target and clear instr_valid (flush), regardless of stall.
REQ-023 SHALL qualify halt only when state=RUN and instr_valid=1; unqualified halt is ignored.
REQ-024 SHALL, on qualified halt, enter HALTED, clear instr_valid, freeze PC, set done=1 on the same edge.
REQ-025 SHALL apply priority halt > branch_taken > stall > normal fetch for simultaneous events.
REQ-026 SHALL hold done=1 throughout HALTED and clear it on the edge leaving HALTED.
REQ-027 SHALL ignore start_req while in RUN.
REQ-028 SHALL increment cycle_count on every edge in RUN (including stalled cycles), saturating at all-ones; hold it in IDLE/HALTED until the next start.
REQ-029 SHALL keep instr_valid=0 and PC frozen in IDLE and HALTED.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-RUN, immediately force state=IDLE, PC=0, instr_out=0, instr_valid=0, pc_out=0, done=0, cycle_count=0.
REQ-031 SHALL resume operation only via start_req after rst_n is released.

Verification
REQ-032 Reset release, pulse start_req, memory word k at address k: edges after start show instr_out=0,1,2,… with pc_out matching, instr_valid=1 from second edge after start.
REQ-033 Stall high 3 cycles while instr_out=0x005: instr_out, pc_out, PC held 3 cycles, cycle_count still increments by 3.
REQ-034 branch_taken with target 0x3F0 while stall=1: next edge instr_valid=0, PC=0x3F0; following edge pc_out=0x3F0.
REQ-035 Halt asserted with branch_taken in same cycle, instr_valid=1: state HALTED, done=1, PC unchanged, instr_valid=0; subsequent start_req restarts at address 0 with done=0.
REQ-036 Branch to 0x3FF, run two cycles: pc_out sequence 0x3FF, 0x000; cycle_count saturates at 0xFFFF when forced long run.
REQ-037 rst_n low mid-RUN: all outputs zero asynchronously before next edge; start_req ignored until rst_n high.
